// File: rtl/decrypt_sequencer.sv
// Vector LWE decrypt sequencer: holds the secret key and accumulates top + sum(key[i]*bot[i])
// over a beat stream, then presents the low plaintext bits on a valid/ready output.
module decrypt_sequencer #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int DIMENSION        = 4,
  parameter int IDX_WIDTH        = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               key_we,
  input  logic        [IDX_WIDTH-1:0]        key_addr,
  input  logic        [CIPHERTEXT_WIDTH-1:0] key_data,
  input  logic                               ct_valid,
  output logic                               ct_ready,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] ct_top,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] ct_bot,
  input  logic                               ct_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic        [PLAINTEXT_WIDTH-1:0]  result,
  output logic                               err,
  output logic                               busy
);

  localparam logic [IDX_WIDTH:0]   DIM_EXT  = (IDX_WIDTH + 1)'(DIMENSION);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DIMENSION - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  state_e                       state_q;
  logic [CIPHERTEXT_WIDTH-1:0]  key_q [DIMENSION];
  logic [CIPHERTEXT_WIDTH-1:0]  acc_q;
  logic [IDX_WIDTH-1:0]         idx_q;
  logic                         err_q;
  logic [PLAINTEXT_WIDTH-1:0]   result_q;

  logic [CIPHERTEXT_WIDTH-1:0]  key_sel;
  logic [CIPHERTEXT_WIDTH-1:0]  base;
  logic [CIPHERTEXT_WIDTH-1:0]  prod;
  logic [CIPHERTEXT_WIDTH-1:0]  acc_d;
  logic                         beat;
  logic                         key_ok;
  logic                         key_bad;

  assign ct_ready  = (state_q != S_OUTPUT);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign err       = err_q;

  assign beat    = ct_valid && ct_ready;
  assign key_ok  = key_we && (state_q == S_IDLE) && ({1'b0, key_addr} < DIM_EXT);
  assign key_bad = key_we && !key_ok;

  // Beat 0 (in IDLE) always multiplies by key[0]; later beats use key[idx].
  always_comb begin
    key_sel = key_q[0];
    for (int i = 1; i < DIMENSION; i++) begin
      key_sel = ((state_q == S_ACCUM) && (idx_q == IDX_WIDTH'(i))) ? key_q[i] : key_sel;
    end
  end

  // Truncating mod-2^CW arithmetic makes signed and unsigned products identical.
  assign base  = (state_q == S_IDLE) ? $unsigned(ct_top) : acc_q;
  assign prod  = key_sel * $unsigned(ct_bot);
  assign acc_d = base + prod;

  // Sequencer FSM with key storage, accumulator and registered result/err.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < DIMENSION; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      err_q <= key_bad;
      for (int i = 0; i < DIMENSION; i++) begin
        if (key_ok && (key_addr == IDX_WIDTH'(i))) begin
          key_q[i] <= key_data;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (beat) begin
            acc_q <= acc_d;
            idx_q <= IDX_ONE;
            if (DIMENSION == 1) begin
              if (ct_last) begin
                state_q  <= S_OUTPUT;
                result_q <= acc_d[PLAINTEXT_WIDTH-1:0];
              end else begin
                err_q   <= 1'b1;
                state_q <= S_DRAIN;
              end
            end else if (ct_last) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            if (idx_q == LAST_IDX) begin
              if (ct_last) begin
                state_q  <= S_OUTPUT;
                result_q <= acc_d[PLAINTEXT_WIDTH-1:0];
              end else begin
                err_q   <= 1'b1;
                state_q <= S_DRAIN;
              end
            end else if (ct_last) begin
              err_q   <= 1'b1;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (beat && ct_last) begin
            state_q <= S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/decrypt_sequencer.md
# decrypt_sequencer

Controller and scheduler for LWE decryption with DIMENSION > 1. It holds the secret-key vector and accepts a ciphertext as a stream of DIMENSION beats. Each beat drives one multiply-accumulate step of the form `top + key·bot`. After the last beat it presents the reduced plaintext on a valid/ready output. It sits between the ciphertext source (host/DMA interface) and the plaintext consumer, and replaces the single-shot scalar decrypt when keys are vectors.

## Interface
- `PLAINTEXT_WIDTH`, 6: plaintext bits; the plaintext modulus is 2^PLAINTEXT_WIDTH.
- `CIPHERTEXT_WIDTH`, 10: ciphertext bits; the ciphertext modulus is 2^CIPHERTEXT_WIDTH.
- `DIMENSION`, 4: key/vector length, ≥1.
- `IDX_WIDTH`, 2: index width, ≥ clog2(DIMENSION), ≥1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset (1 = reset).
- `key_we`  in  1  key register write enable.
- `key_addr`  in  IDX_WIDTH  key element index.
- `key_data`  in  CIPHERTEXT_WIDTH  key element value (unsigned).
- `ct_valid`  in  1  ciphertext beat valid.
- `ct_ready`  out  1  ciphertext beat accepted when `ct_valid && ct_ready`.
- `ct_top`  in  signed CIPHERTEXT_WIDTH  scalar term b; sampled only on beat 0.
- `ct_bot`  in  signed CIPHERTEXT_WIDTH  vector element a[i] for beat i.
- `ct_last`  in  1  marks the final beat of a ciphertext.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  PLAINTEXT_WIDTH  decrypted plaintext.
- `err`  out  1  one-cycle pulse on a length error or an illegal key write.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Key storage:
  - DIMENSION registers, each CIPHERTEXT_WIDTH bits, all cleared to 0 on reset.
  - A write takes effect on the next cycle, and only when state = IDLE.
  - `key_we` in any other state is dropped and pulses `err`.
  - `key_addr` ≥ DIMENSION is dropped and pulses `err`.
- Arithmetic:
  - All accumulation is mod 2^CIPHERTEXT_WIDTH: keep the low CIPHERTEXT_WIDTH bits of every sum and product. Signed and unsigned interpretations are therefore equivalent.
  - acc = (b + Σ key[i]·a[i]) mod 2^CIPHERTEXT_WIDTH.
  - result = acc[PLAINTEXT_WIDTH-1:0], matching the scalar decrypt convention.
- States:
  - IDLE: `ct_ready`=1.
    - On an accepted beat: acc ← ct_top + key[0]·ct_bot, idx ← 1.
    - If DIMENSION=1 and ct_last=1, go to OUTPUT.
    - If DIMENSION=1 and ct_last=0, pulse `err` and go to DRAIN.
    - If DIMENSION>1 and ct_last=1, pulse `err` and stay in IDLE.
    - Otherwise go to ACCUM.
  - ACCUM: `ct_ready`=1.
    - On an accepted beat: acc ← acc + key[idx]·ct_bot, then:
    - If idx < DIMENSION-1 and ct_last=0: idx++ and stay in ACCUM.
    - If idx < DIMENSION-1 and ct_last=1 (early last): pulse `err`, discard acc, go to IDLE.
    - If idx = DIMENSION-1 and ct_last=1: go to OUTPUT.
    - If idx = DIMENSION-1 and ct_last=0 (long packet): pulse `err` and go to DRAIN.
  - DRAIN: `ct_ready`=1. Discard beats; on an accepted beat with ct_last=1, go to IDLE. No output is produced.
  - OUTPUT: `ct_ready`=0, `out_valid`=1, `result` held stable. On `out_ready`=1, go to IDLE.
- ct_top on beats other than beat 0 is ignored.
- Cycles with `ct_valid`=0 in IDLE, ACCUM or DRAIN change nothing.

## Timing
- Reset values:
  - state=IDLE, acc=0, idx=0, all keys=0.
  - `out_valid`=0, `result`=0, `err`=0, `busy`=0.
  - `ct_ready`=1 in the first cycle after reset deasserts.
- Reset mid-operation: a reset in any state aborts the operation and discards the partial acc. No output or `err` is produced for the aborted ciphertext.
- Latency: if the last beat is accepted at cycle t, `out_valid`=1 from t+1.
- Throughput: no back-to-back overlap. The minimum period is DIMENSION + 1 cycles per ciphertext when `out_ready` is held at 1.
- `out_valid`, once high, stays high with a constant `result` until the handshake completes.
- After the `out_ready` handshake in cycle t, IDLE is entered at t+1. `ct_ready` is therefore 0 in cycle t.
- `err` is registered: it is high in the cycle after the offending beat or write, for exactly 1 cycle.
- A simultaneous `key_we` and beat acceptance in IDLE is legal. The beat uses the old key value, and the write lands at the next edge.

## Test plan
- Load keys {3,5,7,1}. Stream top=100, bot={2,-1,4,10}, with ct_last on beat 3 and out_ready=1:
  - acc = 139, so `result`=11.
  - `out_valid` rises exactly 1 cycle after beat 3.
- Load keys {1023,0,0,0}. Stream top=1000, bot={2,0,0,0}:
  - acc wraps to 998, so `result`=38.
  - Checks mod-2^10 wrap and signed/unsigned equivalence.
- Assert ct_last on beat 2:
  - `err` pulses once, `out_valid` stays 0, and the next ciphertext decodes correctly.
- Send 6 beats with ct_last only on beat 5:
  - `err` pulses after beat 3.
  - Beats 4–5 are drained, with no output.
- Complete a ciphertext and hold `out_ready`=0 for 5 cycles:
  - `result` is stable, `ct_ready`=0 and `busy`=1 throughout.
  - A `key_we` pulse during this window pulses `err` and leaves the key unchanged.
- Assert reset after beat 1, then stream top=37 with all keys still zero after reset:
  - `result`=37.
  - No output appears for the aborted ciphertext.
